// File: rtl/fetch_req_ctrl_pkg.sv
// Shared definitions for the instruction-fetch request controller:
// FSM encodings, reset PC, instruction step and the {pc, instr} entry
// layout used by the fetch controller, instruction buffer and decode.
package fetch_req_ctrl_pkg;

    typedef enum logic {
        S_BOOT  = 1'b0,
        S_FETCH = 1'b1
    } state_t;

    localparam logic [31:0] DEF_RESET_PC   = 32'hBFC0_0000;
    localparam int          INSTR_STEP     = 4;
    localparam int          DEF_ADDR_WIDTH = 32;
    localparam int          DEF_DATA_WIDTH = 32;

    // Buffer entry layout: PC in the upper field, instruction word below.
    typedef struct packed {
        logic [DEF_ADDR_WIDTH-1:0] pc;
        logic [DEF_DATA_WIDTH-1:0] instr;
    } fetch_entry_t;

    function automatic fetch_entry_t make_entry(input logic [DEF_ADDR_WIDTH-1:0] pc,
                                                input logic [DEF_DATA_WIDTH-1:0] instr);
        fetch_entry_t e;
        e.pc    = pc;
        e.instr = instr;
        return e;
    endfunction

endpackage

// File: rtl/fetch_req_ctrl_updown_cnt.sv
// updown_cnt: plain up/down counter with synchronous load (load wins).
// A simultaneous inc and dec leaves the count unchanged. No saturation:
// the surrounding logic guarantees the count stays in range.
module updown_cnt #(
    parameter int              W       = 3,
    parameter logic [W-1:0]    RST_VAL = '0
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] cnt
);

    // Count register: load has priority over inc/dec.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= RST_VAL;
        end else if (load) begin
            cnt <= load_val;
        end else begin
            cnt <= cnt + W'(inc) - W'(dec);
        end
    end

endmodule

// File: rtl/fetch_req_ctrl.sv
// fetch_req_ctrl: sequential instruction-fetch request generator with
// outstanding-request and downstream-credit tracking. Responses to
// requests issued before a flush are discarded via the cancel counter.
// Optional macro FETCH_PERF_CNT_EN adds perf_kept / perf_dropped counters.
module fetch_req_ctrl
    import fetch_req_ctrl_pkg::*;
#(
    parameter int                      ADDR_WIDTH = 32,
    parameter int                      DATA_WIDTH = 32,
    parameter int                      MAX_OUTST  = 4,
    parameter int                      BUF_SLOTS  = 3,
    parameter int                      CNT_WIDTH  = 3,
    parameter logic [ADDR_WIDTH-1:0]   RESET_PC   = ADDR_WIDTH'(DEF_RESET_PC)
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  logic                             flush,
    input  logic [ADDR_WIDTH-1:0]            flush_pc,
    output logic                             req_valid,
    input  logic                             req_ready,
    output logic [ADDR_WIDTH-1:0]            req_addr,
    input  logic                             resp_valid,
    input  logic [DATA_WIDTH-1:0]            resp_data,
    output logic                             buf_wen,
    output logic [ADDR_WIDTH+DATA_WIDTH-1:0] buf_data,
    input  logic                             buf_pop,
    output logic                             buf_clear
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]                      perf_kept,
    output logic [31:0]                      perf_dropped
`endif
);

    localparam logic [ADDR_WIDTH-1:0] STEP      = ADDR_WIDTH'(INSTR_STEP);
    localparam logic [CNT_WIDTH-1:0]  OUTST_MAX = CNT_WIDTH'(MAX_OUTST);
    localparam logic [CNT_WIDTH-1:0]  SLOTS     = CNT_WIDTH'(BUF_SLOTS);

    state_t                          state;
    state_t                          state_nxt;
    logic [ADDR_WIDTH-1:0]           pc;
    logic [ADDR_WIDTH-1:0]           resp_pc;
    logic [CNT_WIDTH-1:0]            outst;
    logic [CNT_WIDTH-1:0]            credit;
    logic [CNT_WIDTH-1:0]            cancel;
    logic                            wen_q;
    logic [ADDR_WIDTH+DATA_WIDTH-1:0] data_q;
    logic                            issue;
    logic                            cancel_nz;
    logic                            keep;

    assign issue     = req_valid & req_ready;
    assign cancel_nz = (cancel != '0);
    // A response survives only if nothing is being cancelled and no flush is in progress.
    assign keep      = resp_valid & !cancel_nz & !flush;

    // FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: one boot cycle, then fetch forever; flush does not affect state.
    always_comb begin
        state_nxt = state;
        case (state)
            S_BOOT:  state_nxt = S_FETCH;
            S_FETCH: state_nxt = S_FETCH;
            default: state_nxt = S_BOOT;
        endcase
    end

    // FSM outputs: request gating, buffer write/clear.
    always_comb begin
        req_valid = (state == S_FETCH) & !flush & (credit != '0) & (outst != OUTST_MAX);
        req_addr  = pc;
        buf_wen   = wen_q & !flush;
        buf_data  = data_q;
        buf_clear = flush;
    end

    // Request and response PCs; flush redirects both.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc      <= RESET_PC;
            resp_pc <= RESET_PC;
        end else if (flush) begin
            pc      <= flush_pc;
            resp_pc <= flush_pc;
        end else begin
            if (issue) begin
                pc <= pc + STEP;
            end
            if (keep) begin
                resp_pc <= resp_pc + STEP;
            end
        end
    end

    // Buffer write stage: register surviving responses tagged with their PC.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wen_q  <= 1'b0;
            data_q <= '0;
        end else begin
            wen_q <= keep;
            if (keep) begin
                data_q <= {resp_pc, resp_data};
            end
        end
    end

    // In-flight requests, including cancelled ones; never reloaded by flush.
    updown_cnt #(.W(CNT_WIDTH), .RST_VAL('0)) u_outst (
        .clk      (clk),
        .resetn   (resetn),
        .load     (1'b0),
        .load_val ('0),
        .inc      (issue),
        .dec      (resp_valid),
        .cnt      (outst)
    );

    // Free buffer slots, reserved at issue; flush empties the buffer so credit refills.
    updown_cnt #(.W(CNT_WIDTH), .RST_VAL(SLOTS)) u_credit (
        .clk      (clk),
        .resetn   (resetn),
        .load     (flush),
        .load_val (SLOTS),
        .inc      (buf_pop),
        .dec      (issue),
        .cnt      (credit)
    );

    // Responses still to discard; a response in the flush cycle is already accounted for.
    updown_cnt #(.W(CNT_WIDTH), .RST_VAL('0)) u_cancel (
        .clk      (clk),
        .resetn   (resetn),
        .load     (flush),
        .load_val (outst - CNT_WIDTH'(resp_valid)),
        .inc      (1'b0),
        .dec      (resp_valid & cancel_nz),
        .cnt      (cancel)
    );

`ifdef FETCH_PERF_CNT_EN
    // Performance counters: pushes into the buffer and discarded responses.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_kept    <= '0;
            perf_dropped <= '0;
        end else begin
            if (buf_wen) begin
                perf_kept <= perf_kept + 32'd1;
            end
            if (resp_valid & (cancel_nz | flush)) begin
                perf_dropped <= perf_dropped + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_req_ctrl.sv
// Testbench for fetch_req_ctrl (default build, default parameters).
module tb_fetch_req_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        flush;
    logic [31:0] flush_pc;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        buf_wen;
    logic [63:0] buf_data;
    logic        buf_pop;
    logic        buf_clear;

    int n_cmp = 0;
    int n_bad = 0;
    logic [63:0] exp_q[$];
    logic [31:0] iss_q[$];

    always #5 clk = ~clk;

    fetch_req_ctrl dut (
        .clk        (clk),
        .resetn     (resetn),
        .flush      (flush),
        .flush_pc   (flush_pc),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .buf_wen    (buf_wen),
        .buf_data   (buf_data),
        .buf_pop    (buf_pop),
        .buf_clear  (buf_clear)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_iss(input string name, input int idx, input logic [31:0] exp);
        logic [31:0] a;
        a = 32'hDEAD_DEAD;
        if (iss_q.size() > idx) a = iss_q[idx];
        chk(name, {32'h0, a}, {32'h0, exp});
    endtask

    // One cycle: drive just after the rising edge, return at the falling edge.
    task automatic cyc(input logic rr, input logic rv, input logic [31:0] rd,
                       input logic bp, input logic fl, input logic [31:0] fpc);
        @(posedge clk);
        #1;
        req_ready  = rr;
        resp_valid = rv;
        resp_data  = rd;
        buf_pop    = bp;
        flush      = fl;
        flush_pc   = fpc;
        @(negedge clk);
    endtask

    // Assert reset mid-operation, check reset outputs, release; returns in boot cycle 0.
    task automatic start(input string tag);
        @(posedge clk);
        #1;
        resetn     = 1'b0;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_data  = '0;
        buf_pop    = 1'b0;
        flush      = 1'b0;
        flush_pc   = '0;
        @(negedge clk);
        chk({tag, "_rst_valid"}, req_valid, 1'b0);
        chk({tag, "_rst_wen"},   buf_wen,   1'b0);
        chk({tag, "_rst_addr"},  req_addr,  32'hBFC0_0000);
        exp_q.delete();
        iss_q.delete();
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        chk({tag, "_boot_valid"}, req_valid, 1'b0);
    endtask

    initial begin
        resetn     = 1'b0;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_data  = '0;
        buf_pop    = 1'b0;
        flush      = 1'b0;
        flush_pc   = '0;
        fork
            // Monitor: logs request handshakes, checks every buffer push against the scoreboard.
            begin
                forever begin
                    @(negedge clk);
                    if (resetn) begin
                        if (req_valid && req_ready) iss_q.push_back(req_addr);
                        if (buf_wen) begin
                            if (exp_q.size() == 0) begin
                                n_cmp++;
                                n_bad++;
                                $display("FAIL push_unexpected: got %h, expected no push", buf_data);
                            end else begin
                                chk("push", buf_data, exp_q.pop_front());
                            end
                        end
                    end
                end
            end
            // Stimulus.
            begin
                // 1: streaming with a 1-cycle memory.
                start("s1");
                exp_q.push_back({32'hBFC0_0000, 32'h11});
                exp_q.push_back({32'hBFC0_0004, 32'h22});
                exp_q.push_back({32'hBFC0_0008, 32'h33});
                cyc(1, 0, 0, 1, 0, 0);
                chk("s1_c1_valid", req_valid, 1'b1);
                chk("s1_c1_addr", req_addr, 32'hBFC0_0000);
                cyc(1, 1, 32'h11, 1, 0, 0);
                chk("s1_c2_addr", req_addr, 32'hBFC0_0004);
                cyc(1, 1, 32'h22, 1, 0, 0);
                chk("s1_c3_addr", req_addr, 32'hBFC0_0008);
                chk("s1_c3_wen", buf_wen, 1'b1);
                cyc(0, 1, 32'h33, 0, 0, 0);
                chk("s1_c4_wen", buf_wen, 1'b1);
                cyc(0, 0, 0, 0, 0, 0);
                chk("s1_c5_wen", buf_wen, 1'b1);
                cyc(0, 0, 0, 0, 0, 0);
                chk("s1_c6_wen", buf_wen, 1'b0);
                chk("s1_nreq", iss_q.size(), 3);

                // 2: credit exhaustion, one pop releases a 4th request.
                start("s2");
                for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0);
                cyc(1, 0, 0, 0, 0, 0);
                chk("s2_c4_nocredit", req_valid, 1'b0);
                cyc(1, 0, 0, 0, 0, 0);
                chk("s2_c5_nocredit", req_valid, 1'b0);
                cyc(1, 0, 0, 1, 0, 0);
                chk("s2_c6_pop_valid", req_valid, 1'b0);
                cyc(1, 0, 0, 0, 0, 0);
                chk("s2_c7_valid", req_valid, 1'b1);
                chk("s2_c7_addr", req_addr, 32'hBFC0_000C);
                cyc(1, 0, 0, 0, 0, 0);
                chk("s2_c8_valid", req_valid, 1'b0);
                cyc(0, 0, 0, 0, 0, 0);
                chk("s2_nreq", iss_q.size(), 4);
                chk_iss("s2_req3_addr", 3, 32'hBFC0_000C);

                // 3: outstanding limit with pops keeping credit available.
                start("s3");
                exp_q.push_back({32'hBFC0_0000, 32'hA1});
                for (int i = 0; i < 4; i++) cyc(1, 0, 0, 1, 0, 0);
                cyc(0, 0, 0, 0, 0, 0);
                chk("s3_c5_full", req_valid, 1'b0);
                cyc(1, 0, 0, 0, 0, 0);
                chk("s3_c6_full", req_valid, 1'b0);
                cyc(1, 1, 32'hA1, 0, 0, 0);
                chk("s3_c7_full", req_valid, 1'b0);
                cyc(0, 0, 0, 0, 0, 0);
                chk("s3_c8_valid", req_valid, 1'b1);
                chk("s3_c8_addr", req_addr, 32'hBFC0_0010);
                chk("s3_c8_wen", buf_wen, 1'b1);
                cyc(0, 0, 0, 0, 0, 0);
                chk("s3_nreq", iss_q.size(), 4);

                // 4: flush with 3 outstanding; 3 responses dropped, 4th kept.
                start("s4");
                exp_q.push_back({32'h8000_0100, 32'h44});
                for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0);
                cyc(1, 0, 0, 0, 1, 32'h8000_0100);
                chk("s4_c4_clear", buf_clear, 1'b1);
                chk("s4_c4_valid", req_valid, 1'b0);
                cyc(1, 0, 0, 0, 0, 0);
                chk("s4_c5_valid", req_valid, 1'b1);
                chk("s4_c5_addr", req_addr, 32'h8000_0100);
                chk("s4_c5_clear", buf_clear, 1'b0);
                cyc(0, 1, 32'hD0A, 0, 0, 0);
                chk("s4_c6_full", req_valid, 1'b0);
                cyc(0, 1, 32'hD0B, 0, 0, 0);
                cyc(0, 1, 32'hD0C, 0, 0, 0);
                cyc(0, 1, 32'h44, 0, 0, 0);
                chk("s4_c9_wen", buf_wen, 1'b0);
                cyc(0, 0, 0, 0, 0, 0);
                chk("s4_c10_wen", buf_wen, 1'b1);
                cyc(0, 0, 0, 0, 0, 0);

                // 5: flush coinciding with a response and a pending buffer write.
                start("s5");
                exp_q.push_back({32'h0000_1000, 32'h77});
                cyc(1, 0, 0, 0, 0, 0);
                cyc(1, 0, 0, 0, 0, 0);
                cyc(1, 1, 32'h50, 0, 0, 0);
                cyc(1, 1, 32'h55, 0, 1, 32'h0000_1000);
                chk("s5_c4_wen", buf_wen, 1'b0);
                chk("s5_c4_valid", req_valid, 1'b0);
                chk("s5_c4_clear", buf_clear, 1'b1);
                cyc(1, 0, 0, 0, 0, 0);
                chk("s5_c5_valid", req_valid, 1'b1);
                chk("s5_c5_addr", req_addr, 32'h0000_1000);
                cyc(0, 1, 32'h66, 0, 0, 0);
                cyc(0, 1, 32'h77, 0, 0, 0);
                cyc(0, 0, 0, 0, 0, 0);
                chk("s5_c8_wen", buf_wen, 1'b1);

                // PC wrap across 2^32.
                cyc(0, 0, 0, 0, 1, 32'hFFFF_FFFC);
                cyc(1, 0, 0, 0, 0, 0);
                chk("s5_wrap_addr0", req_addr, 32'hFFFF_FFFC);
                cyc(1, 0, 0, 0, 0, 0);
                chk("s5_wrap_addr1", req_addr, 32'h0000_0000);

                // Back-to-back flushes; the last target wins, both outstanding dropped.
                exp_q.push_back({32'h0000_3000, 32'h88});
                cyc(1, 0, 0, 0, 1, 32'h0000_2000);
                chk("s5_ff1_valid", req_valid, 1'b0);
                cyc(1, 0, 0, 0, 1, 32'h0000_3000);
                chk("s5_ff2_valid", req_valid, 1'b0);
                cyc(1, 0, 0, 0, 0, 0);
                chk("s5_ff_valid", req_valid, 1'b1);
                chk("s5_ff_addr", req_addr, 32'h0000_3000);
                cyc(0, 1, 32'hAA, 0, 0, 0);
                cyc(0, 1, 32'hBB, 0, 0, 0);
                cyc(0, 1, 32'h88, 0, 0, 0);
                cyc(0, 0, 0, 0, 0, 0);
                chk("s5_ff_wen", buf_wen, 1'b1);
                cyc(0, 0, 0, 0, 0, 0);
                chk("sb_drained", exp_q.size(), 0);
            end
        join_any
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
